// File: rtl/i2s_loopback_pkg.sv
// Shared constants and slot helpers for the I2S loopback.
package i2s_loopback_pkg;

  localparam int BCLK_DIV    = 8;   // clk_25m cycles per BCLK period (even)
  localparam int DATA_W      = 24;  // audio sample width
  localparam int SLOT_W      = 32;  // BCLK periods per channel slot
  localparam int FRAME_CNT_W = 9;   // 64 BCLK x 8 clocks = 512 counts

  localparam int PHASE_W    = $clog2(BCLK_DIV);       // phase field p
  localparam int BIT_W      = FRAME_CNT_W - PHASE_W;  // bit index field b
  localparam int SLOT_IDX_W = $clog2(SLOT_W);         // slot bit s

  // Phase at which BCLK is driven high (rising edge).
  localparam logic [PHASE_W-1:0] PHASE_RISE = PHASE_W'(BCLK_DIV / 2);

  // Last count of a frame; LRCLK falls here, one clock ahead of the frame start.
  localparam logic [FRAME_CNT_W-1:0] CNT_LAST = '1;

  // LRCLK rises one clock ahead of the right slot's first BCLK fall.
  localparam logic [FRAME_CNT_W-1:0] LR_RISE_CNT = FRAME_CNT_W'(SLOT_W * BCLK_DIV - 1);

  // Last slot bit that carries data (bit 0 is the one-BCLK delay bit).
  localparam logic [SLOT_IDX_W-1:0] SLOT_DATA_LAST = SLOT_IDX_W'(DATA_W);

  // True for slot bits 1..DATA_W, which carry sample data MSB first.
  function automatic logic is_data_slot(input logic [SLOT_IDX_W-1:0] s);
    return (s != '0) && (s <= SLOT_DATA_LAST);
  endfunction

  // Sample bit carried by data slot bit s: slot 1 -> bit 23, slot 24 -> bit 0.
  function automatic logic [SLOT_IDX_W-1:0] data_bit_index(input logic [SLOT_IDX_W-1:0] s);
    return SLOT_DATA_LAST - s;
  endfunction

endpackage

// File: rtl/i2s_loopback_rx.sv
// I2S deserializer: shifts in the 24 data bits of each slot and emits the word
// with a one-cycle valid pulse for the channel it belongs to.
//
// Handshake: o_*_valid is a single-cycle pulse with no ready/back-pressure;
// o_*_data holds the word from that pulse until the next word of the channel.
module i2s_loopback_rx
  import i2s_loopback_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sample_en,  // BCLK rising-edge phase
  input  logic [BIT_W-1:0]  i_bit_idx,    // frame bit index b
  input  logic              i_data,       // serial data from the mic
  output logic              o_left_valid,
  output logic [DATA_W-1:0] o_left_data,
  output logic              o_right_valid,
  output logic [DATA_W-1:0] o_right_data
);

  logic [DATA_W-1:0]     r_shift;
  logic                  r_left_valid;
  logic                  r_right_valid;
  logic [DATA_W-1:0]     r_left_data;
  logic [DATA_W-1:0]     r_right_data;
  logic [SLOT_IDX_W-1:0] w_slot;
  logic [DATA_W-1:0]     w_word;

  assign w_slot = i_bit_idx[SLOT_IDX_W-1:0];
  assign w_word = {r_shift[DATA_W-2:0], i_data};

  // Shift data bits on BCLK rise; publish the word after the last data bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift       <= '0;
      r_left_valid  <= 1'b0;
      r_right_valid <= 1'b0;
      r_left_data   <= '0;
      r_right_data  <= '0;
    end else begin
      r_left_valid  <= 1'b0;
      r_right_valid <= 1'b0;
      if (i_sample_en && is_data_slot(w_slot)) begin
        r_shift <= w_word;
        if (w_slot == SLOT_DATA_LAST) begin
          if (i_bit_idx[BIT_W-1]) begin
            r_right_valid <= 1'b1;
            r_right_data  <= w_word;
          end else begin
            r_left_valid <= 1'b1;
            r_left_data  <= w_word;
          end
        end
      end
    end
  end

  assign o_left_valid  = r_left_valid;
  assign o_left_data   = r_left_data;
  assign o_right_valid = r_right_valid;
  assign o_right_data  = r_right_data;

endmodule

// File: rtl/i2s_loopback.sv
// I2S audio loopback: generates BCLK/LRCLK from clk_25m, receives 24-bit
// stereo samples from the mic and replays them to the amp one frame later.
module i2s_loopback
  import i2s_loopback_pkg::*;
(
  input  logic clk_25m,
  input  logic rst_n,
  output logic led_r,
  output logic led_g,
  output logic led_b,
  output logic mic_bclk,
  output logic mic_lrclk,
  input  logic mic_data,
  output logic mic_sel,
  output logic amp_bclk,
  output logic amp_lrclk,
  output logic amp_din,
  output logic amp_sd,
  output logic amp_gain
);

  logic [FRAME_CNT_W-1:0] r_cnt;
  logic                   r_bclk;
  logic                   r_lrclk;
  logic                   r_amp_din;
  logic                   r_led_g;
  logic [DATA_W-1:0]      r_hold_l;
  logic [DATA_W-1:0]      r_hold_r;
  logic [DATA_W-1:0]      r_tx_l;
  logic [DATA_W-1:0]      r_tx_r;

  logic [FRAME_CNT_W-1:0] w_cnt_nxt;
  logic [PHASE_W-1:0]     w_ph_nxt;
  logic [BIT_W-1:0]       w_bit_nxt;
  logic [SLOT_IDX_W-1:0]  w_slot_nxt;
  logic                   w_lrclk_nxt;
  logic                   w_sample_en;
  logic                   w_tx_bit;

  logic                   rx_left_valid;
  logic                   rx_right_valid;
  logic [DATA_W-1:0]      rx_left_data;
  logic [DATA_W-1:0]      rx_right_data;

  // Clock outputs and amp_din are registered from the *next* count so every
  // output changes exactly on the clk_25m edge that enters that count.
  assign w_cnt_nxt   = r_cnt + FRAME_CNT_W'(1);
  assign w_ph_nxt    = w_cnt_nxt[PHASE_W-1:0];
  assign w_bit_nxt   = w_cnt_nxt[FRAME_CNT_W-1:PHASE_W];
  assign w_slot_nxt  = w_bit_nxt[SLOT_IDX_W-1:0];
  assign w_lrclk_nxt = (w_cnt_nxt >= LR_RISE_CNT) && (w_cnt_nxt != CNT_LAST);
  assign w_sample_en = (r_cnt[PHASE_W-1:0] == PHASE_RISE);

  // Frame counter and glitch-free BCLK/LRCLK registers.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_bclk  <= (w_ph_nxt >= PHASE_RISE);
      r_lrclk <= w_lrclk_nxt;
    end
  end

  i2s_loopback_rx u_rx (
    .i_clk         (clk_25m),
    .i_rst_n       (rst_n),
    .i_sample_en   (w_sample_en),
    .i_bit_idx     (r_cnt[FRAME_CNT_W-1:PHASE_W]),
    .i_data        (mic_data),
    .o_left_valid  (rx_left_valid),
    .o_left_data   (rx_left_data),
    .o_right_valid (rx_right_valid),
    .o_right_data  (rx_right_data)
  );

  // Hold the latest received word per channel.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else begin
      if (rx_left_valid)  r_hold_l <= rx_left_data;
      if (rx_right_valid) r_hold_r <= rx_right_data;
    end
  end

  // Snapshot both held words into the TX shadow as a new frame begins.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_l <= '0;
      r_tx_r <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_tx_l <= r_hold_l;
      r_tx_r <= r_hold_r;
    end
  end

  // Serial bit for the slot position being entered; zero outside data bits.
  always_comb begin
    w_tx_bit = 1'b0;
    if (is_data_slot(w_slot_nxt)) begin
      if (w_bit_nxt[BIT_W-1]) w_tx_bit = r_tx_r[data_bit_index(w_slot_nxt)];
      else                    w_tx_bit = r_tx_l[data_bit_index(w_slot_nxt)];
    end
  end

  // amp_din updates together with the BCLK falling edge.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_amp_din <= 1'b0;
    end else if (w_ph_nxt == '0) begin
      r_amp_din <= w_tx_bit;
    end
  end

  // Green LED lights once the design is out of reset.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) r_led_g <= 1'b1;
    else        r_led_g <= 1'b0;
  end

  assign mic_bclk  = r_bclk;
  assign amp_bclk  = r_bclk;
  assign mic_lrclk = r_lrclk;
  assign amp_lrclk = r_lrclk;
  assign amp_din   = r_amp_din;
  assign mic_sel   = 1'b0;
  assign amp_sd    = 1'b1;
  assign amp_gain  = 1'b0;
  assign led_r     = 1'b1;
  assign led_g     = r_led_g;
  assign led_b     = 1'b1;

endmodule

// File: tb/tb_i2s_loopback.sv
// Bench for i2s_loopback: acts as mic (drives I2S words on BCLK falls) and as
// amp (captures amp_din on BCLK rises), checking against a frame-level model.
module tb_i2s_loopback;

  logic clk_25m;
  logic rst_n;
  logic led_r, led_g, led_b;
  logic mic_bclk, mic_lrclk, mic_data, mic_sel;
  logic amp_bclk, amp_lrclk, amp_din, amp_sd, amp_gain;

  i2s_loopback dut (
    .clk_25m   (clk_25m),
    .rst_n     (rst_n),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .mic_bclk  (mic_bclk),
    .mic_lrclk (mic_lrclk),
    .mic_data  (mic_data),
    .mic_sel   (mic_sel),
    .amp_bclk  (amp_bclk),
    .amp_lrclk (amp_lrclk),
    .amp_din   (amp_din),
    .amp_sd    (amp_sd),
    .amp_gain  (amp_gain)
  );

  // ---------------- clock / reset ----------------
  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;  // 40 ns period

  int n_checks;
  int n_fail;
  int clk_mis;

  // Received words seen on the rx valid pulses, per channel.
  logic [23:0] got_l_q[$];
  logic [23:0] got_r_q[$];
  // Scoreboard: words the amp must play in the next measured frame, {L,R}.
  logic [47:0] exp_q[$];

  logic prev_lv, prev_rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT event", name);
  endtask

  task automatic tick();
    @(negedge clk_25m);
  endtask

  // Pulse-width monitor and clock-copy monitor.
  always @(negedge clk_25m) begin
    if (dut.rx_left_valid === 1'b1) begin
      check("rx_left_valid_single_cycle", {31'd0, prev_lv}, 32'd0);
      got_l_q.push_back(dut.rx_left_data);
    end
    if (dut.rx_right_valid === 1'b1) begin
      check("rx_right_valid_single_cycle", {31'd0, prev_rv}, 32'd0);
      got_r_q.push_back(dut.rx_right_data);
    end
    prev_lv = dut.rx_left_valid;
    prev_rv = dut.rx_right_valid;
    if (amp_bclk !== mic_bclk || amp_lrclk !== mic_lrclk) clk_mis++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_bclk(input logic lvl, output bit ok);
    logic prev;
    prev = mic_bclk;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (mic_bclk === lvl && prev !== lvl) begin
        ok = 1'b1;
        break;
      end
      prev = mic_bclk;
    end
  endtask

  task automatic wait_lr_fall(output bit ok);
    logic prev;
    prev = mic_lrclk;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (mic_lrclk === 1'b0 && prev === 1'b1) begin
        ok = 1'b1;
        break;
      end
      prev = mic_lrclk;
    end
  endtask

  // One full I2S frame: send l/r as the mic, capture amp_din as the amp.
  task automatic run_frame(input logic [23:0] l, input logic [23:0] r, input bit pad,
                           output logic [23:0] tl, output logic [23:0] tr,
                           output int pad_errs, output bit ok);
    bit e;
    logic [63:0] cap;
    ok = 1'b1;
    tl = '0;
    tr = '0;
    pad_errs = 0;
    cap = '0;
    wait_lr_fall(e);
    if (!e) begin
      ok = 1'b0;
      return;
    end
    got_l_q.delete();
    got_r_q.delete();
    for (int k = 0; k < 64; k++) begin
      int s;
      logic [23:0] w;
      s = k % 32;
      w = (k < 32) ? l : r;
      wait_bclk(1'b0, e);
      if (!e) begin
        ok = 1'b0;
        return;
      end
      if (s >= 1 && s <= 24) mic_data = w[24 - s];
      else                   mic_data = pad;
      wait_bclk(1'b1, e);
      if (!e) begin
        ok = 1'b0;
        return;
      end
      cap[k] = amp_din;
    end
    for (int s = 1; s <= 24; s++) begin
      tl[24 - s] = cap[s];
      tr[24 - s] = cap[32 + s];
    end
    for (int k = 0; k < 64; k++) begin
      if (((k % 32) == 0 || (k % 32) >= 25) && cap[k] !== 1'b0) pad_errs++;
    end
  endtask

  // Run a frame and score RX words, TX words and TX padding against the model.
  task automatic do_frame(input string tag, input logic [23:0] l, input logic [23:0] r,
                          input bit pad, input logic [23:0] exp_l, input logic [23:0] exp_r);
    logic [23:0] tl, tr;
    logic [47:0] exp_tx;
    int pad_errs;
    bit ok;
    run_frame(l, r, pad, tl, tr, pad_errs, ok);
    if (!ok) begin
      timeout_fail({tag, "_frame"});
      return;
    end
    exp_tx = (exp_q.size() > 0) ? exp_q.pop_front() : 48'd0;
    exp_q.push_back({exp_l, exp_r});
    check({tag, "_rx_l_count"}, 32'(got_l_q.size()), 32'd1);
    check({tag, "_rx_r_count"}, 32'(got_r_q.size()), 32'd1);
    if (got_l_q.size() > 0) check({tag, "_rx_l"}, {8'd0, got_l_q[0]}, {8'd0, exp_l});
    if (got_r_q.size() > 0) check({tag, "_rx_r"}, {8'd0, got_r_q[0]}, {8'd0, exp_r});
    check({tag, "_tx_l"}, {8'd0, tl}, {8'd0, exp_tx[47:24]});
    check({tag, "_tx_r"}, {8'd0, tr}, {8'd0, exp_tx[23:0]});
    check({tag, "_tx_pad_zero"}, 32'(pad_errs), 32'd0);
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    bit          pad;
    logic [23:0] exp_rx_l;
    logic [23:0] exp_rx_r;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int n, hi, period, bclk_rise, lr_rise, lr_fall, nz;
    logic pb, plr;

    n_checks = 0;
    n_fail   = 0;
    clk_mis  = 0;
    prev_lv  = 1'b0;
    prev_rv  = 1'b0;
    rst_n    = 1'b0;
    mic_data = 1'b0;

    vecs[0] = '{24'hABCDEF, 24'h000000, 1'b0, 24'hABCDEF, 24'h000000};
    vecs[1] = '{24'h123456, 24'h654321, 1'b0, 24'h123456, 24'h654321};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 24'hFFFFFF};
    vecs[3] = '{24'h000000, 24'h000000, 1'b1, 24'h000000, 24'h000000};
    vecs[4] = '{24'h800001, 24'h7FFFFE, 1'b1, 24'h800001, 24'h7FFFFE};
    vecs[5] = '{24'h5A5A5A, 24'hA5A5A5, 1'b0, 24'h5A5A5A, 24'hA5A5A5};

    repeat (3) tick();
    check("rst_bclk",    {31'd0, mic_bclk},  32'd0);
    check("rst_lrclk",   {31'd0, mic_lrclk}, 32'd0);
    check("rst_amp_din", {31'd0, amp_din},   32'd0);
    check("rst_leds",    {29'd0, led_r, led_g, led_b}, 32'd7);
    check("rst_rx_valid", {30'd0, dut.rx_left_valid, dut.rx_right_valid}, 32'd0);

    // Release reset and time the first clock edges in clk_25m cycles.
    rst_n = 1'b1;
    n = 0; bclk_rise = -1; lr_rise = -1; lr_fall = -1;
    pb = mic_bclk; plr = mic_lrclk;
    for (int i = 0; i < 600; i++) begin
      tick();
      n++;
      if (bclk_rise < 0 && mic_bclk === 1'b1 && pb === 1'b0) bclk_rise = n;
      if (lr_rise < 0 && mic_lrclk === 1'b1 && plr === 1'b0) lr_rise = n;
      if (mic_lrclk === 1'b0 && plr === 1'b1) begin
        lr_fall = n;
        break;
      end
      pb = mic_bclk;
      plr = mic_lrclk;
    end
    check("first_bclk_rise_cnt", 32'(bclk_rise), 32'd4);
    check("first_lrclk_rise_cnt", 32'(lr_rise), 32'd255);
    check("first_lrclk_fall_cnt", 32'(lr_fall), 32'd511);
    check("static_pins", {28'd0, amp_sd, mic_sel, amp_gain, led_g}, 32'h8);
    check("leds_run", {29'd0, led_r, led_g, led_b}, 32'd5);

    // BCLK high time and period.
    wait_bclk(1'b1, ok);
    if (!ok) timeout_fail("bclk_rise");
    hi = 0; period = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      period++;
      if (mic_bclk === 1'b1 && hi == 0) continue;
      if (mic_bclk === 1'b0 && hi == 0) hi = period;
      if (mic_bclk === 1'b1 && hi != 0) break;
    end
    check("bclk_high_ns", 32'(hi * 40), 32'd160);
    check("bclk_period_ns", 32'(period * 40), 32'd320);

    // LRCLK period between consecutive falling edges.
    wait_lr_fall(ok);
    if (!ok) timeout_fail("lrclk_fall_a");
    n = 0;
    plr = mic_lrclk;
    for (int i = 0; i < 600; i++) begin
      tick();
      n++;
      if (mic_lrclk === 1'b0 && plr === 1'b1) break;
      plr = mic_lrclk;
    end
    check("lrclk_period_ns", 32'(n * 40), 32'd20480);

    // Frames so far carried silence; the first measured frame replays zeros.
    exp_q.delete();
    exp_q.push_back(48'd0);

    for (int i = 0; i < 6; i++)
      do_frame($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].pad,
               vecs[i].exp_rx_l, vecs[i].exp_rx_r);

    for (int i = 0; i < 6; i++) begin
      logic [23:0] l, r;
      bit pad;
      l = 24'($urandom());
      r = 24'($urandom());
      pad = 1'($urandom_range(0, 1));
      do_frame($sformatf("rand%0d", i), l, r, pad, l, r);
    end

    // Reset in the middle of a left word.
    wait_lr_fall(ok);
    if (!ok) timeout_fail("mid_reset_sync");
    for (int k = 0; k < 10; k++) begin
      wait_bclk(1'b0, ok);
      mic_data = 1'b1;
    end
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_bclk",    {31'd0, mic_bclk},  32'd0);
    check("mid_rst_lrclk",   {31'd0, mic_lrclk}, 32'd0);
    check("mid_rst_amp_din", {31'd0, amp_din},   32'd0);
    check("mid_rst_leds",    {29'd0, led_r, led_g, led_b}, 32'd7);
    check("mid_rst_rx_l_data", {8'd0, dut.rx_left_data},  32'd0);
    check("mid_rst_rx_r_data", {8'd0, dut.rx_right_data}, 32'd0);
    repeat (2) tick();
    mic_data = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(48'd0);

    // The frame entered straight out of reset must play silence.
    nz = 0;
    for (int i = 0; i < 510; i++) begin
      tick();
      if (amp_din !== 1'b0) nz++;
    end
    check("post_rst_frame0_amp_din_nonzero", 32'(nz), 32'd0);

    do_frame("post_rst_a", 24'hC0FFEE, 24'h0BEEF0, 1'b0, 24'hC0FFEE, 24'h0BEEF0);
    do_frame("post_rst_b", 24'h000001, 24'h800000, 1'b1, 24'h000001, 24'h800000);

    check("clk_copies_mismatch_cycles", 32'(clk_mis), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
